// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for the multi-cycle RV32I core. It sequences the shared
//   ALU, the register file and the unified memory port through the
//   FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK steps of each instruction.
//
//   Optional build macro: MC_CTRL_PERF_EN adds the cycle_cnt and instret_cnt
//   performance counters. The FSM behaves identically with or without it.
//
// Ports
//   clk            in   core clock, rising edge
//   rst_n          in   synchronous reset, active-low
//   opcode[6:0]    in   instruction register [6:0]
//   funct3[2:0]    in   instruction register [14:12]
//   alu_zero       in   ALU result == 0
//   alu_lt         in   ALU less-than flag (signedness chosen by the datapath)
//   mem_ready      in   memory completes the current request this cycle
//   mem_req        out  memory access request
//   mem_we         out  store
//   i_or_d         out  0 = address from PC, 1 = address from ALUOut
//   ir_write       out  load the instruction register
//   pc_write       out  load the PC (also latches oldPC)
//   pc_src         out  0 = ALU result, 1 = ALUOut
//   alu_op[1:0]    out  00 add, 01 sub/compare, 10 R-type, 11 I-type
//   alu_src_a[1:0] out  00 PC, 01 oldPC, 10 rs1, 11 zero
//   alu_src_b[1:0] out  00 rs2, 01 constant 4, 10 imm
//   reg_write      out  register file write
//   wb_sel[1:0]    out  00 ALUOut, 01 memory data, 10 PC
//   illegal_instr  out  sticky trap flag
//   instr_retired  out  one-cycle pulse per completed instruction
//   cycle_cnt      out  (MC_CTRL_PERF_EN) cycles spent outside TRAP
//   instret_cnt    out  (MC_CTRL_PERF_EN) retired instructions
// -----------------------------------------------------------------------------
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        alu_zero,
   input  logic        alu_lt,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        i_or_d,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic [1:0]  alu_op,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic        illegal_instr,
   output logic        instr_retired
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR, S_MEM_RD,
      S_LOAD_WB, S_MEM_WR, S_BRANCH, S_JAL, S_LUI_WB, S_TRAP
   } state_t;

   state_t r_state;
   logic   r_illegal;
   logic   w_br_valid;
   logic   w_br_taken;

   // funct3 010/011 are not branch encodings and send the core to TRAP.
   assign w_br_valid = (funct3[2:1] != 2'b01);

   always_comb begin
      case (funct3)
         3'b000:          w_br_taken = alu_zero;
         3'b001:          w_br_taken = !alu_zero;
         3'b100, 3'b110:  w_br_taken = alu_lt;
         3'b101, 3'b111:  w_br_taken = !alu_lt;
         default:         w_br_taken = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register and next-state logic.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH:    if (mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_R:               r_state <= S_EXEC_R;
                  OP_I:               r_state <= S_EXEC_I;
                  OP_LOAD, OP_STORE:  r_state <= S_MEM_ADDR;
                  OP_BRANCH:          r_state <= S_BRANCH;
                  OP_JAL:             r_state <= S_JAL;
                  OP_LUI:             r_state <= S_LUI_WB;
                  default: begin
                     r_state   <= S_TRAP;
                     r_illegal <= 1'b1;
                  end
               endcase
            end
            S_EXEC_R:   r_state <= S_ALU_WB;
            S_EXEC_I:   r_state <= S_ALU_WB;
            S_MEM_ADDR: r_state <= (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) r_state <= S_LOAD_WB;
            S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
            S_BRANCH: begin
               if (w_br_valid) begin
                  r_state <= S_FETCH;
               end else begin
                  r_state   <= S_TRAP;
                  r_illegal <= 1'b1;
               end
            end
            S_TRAP:     r_state <= S_TRAP;
            default:    r_state <= S_FETCH;   // ALU_WB, LOAD_WB, JAL, LUI_WB
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode: combinational from state, with FETCH/MEM waits qualified by
   // mem_ready. Everything is held at 0 while reset is asserted so no request
   // leaks out before the first cycle after release.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output is given a default before the case so no path can
      // leave one unassigned and infer a latch.
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      alu_op        = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      reg_write     = 1'b0;
      wb_sel        = 2'b00;
      instr_retired = 1'b0;
      illegal_instr = r_illegal;

      case (r_state)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;              // PC + 4
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         S_DECODE: begin
            alu_src_a = 2'b01;              // oldPC + imm -> branch/jump target
            alu_src_b = 2'b10;
         end
         S_EXEC_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXEC_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
         end
         S_ALU_WB: begin
            reg_write     = 1'b1;
            instr_retired = 1'b1;
         end
         S_MEM_ADDR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
         end
         S_LOAD_WB: begin
            reg_write     = 1'b1;
            wb_sel        = 2'b01;
            instr_retired = 1'b1;
         end
         S_MEM_WR: begin
            mem_req       = 1'b1;
            mem_we        = 1'b1;
            i_or_d        = 1'b1;
            instr_retired = mem_ready;
         end
         S_BRANCH: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            if (w_br_valid) begin
               instr_retired = 1'b1;
               pc_write      = w_br_taken;
               pc_src        = w_br_taken;
            end
         end
         S_JAL: begin
            pc_write      = 1'b1;
            pc_src        = 1'b1;
            reg_write     = 1'b1;
            wb_sel        = 2'b10;          // PC already holds oldPC + 4
            instr_retired = 1'b1;
         end
         S_LUI_WB: begin
            alu_src_a     = 2'b11;          // 0 + imm
            alu_src_b     = 2'b10;
            reg_write     = 1'b1;
            instr_retired = 1'b1;
         end
         default: ;                         // TRAP: only illegal_instr
      endcase

      if (!rst_n) begin
         mem_req       = 1'b0;
         mem_we        = 1'b0;
         i_or_d        = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         pc_src        = 1'b0;
         alu_op        = 2'b00;
         alu_src_a     = 2'b00;
         alu_src_b     = 2'b00;
         reg_write     = 1'b0;
         wb_sel        = 2'b00;
         instr_retired = 1'b0;
         illegal_instr = 1'b0;
      end
   end

`ifdef MC_CTRL_PERF_EN
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instret_cnt;

   // Both counters wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cycle_cnt   <= 32'd0;
         r_instret_cnt <= 32'd0;
      end else begin
         if (r_state != S_TRAP) r_cycle_cnt   <= r_cycle_cnt + 32'd1;
         if (instr_retired)     r_instret_cnt <= r_instret_cnt + 32'd1;
      end
   end

   assign cycle_cnt   = r_cycle_cnt;
   assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Each instruction is expanded by a
//   per-instruction-class model into a list of cycles (stimulus + required
//   outputs); a driver replays the list and a single compare process checks
//   every cycle. Hand-computed cycle counts and request counts pin the model.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef struct packed {
      logic       req;
      logic       we;
      logic       iod;
      logic       irw;
      logic       pcw;
      logic       pcs;
      logic [1:0] op;
      logic [1:0] a;
      logic [1:0] b;
      logic       rw;
      logic [1:0] wb;
      logic       ill;
      logic       ret;
   } out_t;

   typedef struct packed {
      logic       rst;
      logic       rdy;
      logic [6:0] opc;
      logic [2:0] f3;
      logic       zero;
      logic       lt;
      out_t       exp;
   } step_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic        alu_zero = 1'b0;
   logic        alu_lt = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
   logic [1:0]  alu_op, alu_src_a, alu_src_b, wb_sel;
   logic        reg_write, illegal_instr, instr_retired;
`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
      .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .reg_write(reg_write), .wb_sel(wb_sel),
      .illegal_instr(illegal_instr), .instr_retired(instr_retired)
`ifdef MC_CTRL_PERF_EN
      , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
   );

   always #5 clk = ~clk;

   out_t got;
   assign got = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_op,
                 alu_src_a, alu_src_b, reg_write, wb_sel, illegal_instr,
                 instr_retired};

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Model: expands an instruction into its cycle list from the rules of each
   // instruction class.
   // ---------------------------------------------------------------------------
   step_t      q[$];
   logic [6:0] m_opc;
   logic [2:0] m_f3;
   logic       m_zero, m_lt;
   logic       tog = 1'b0;   // mem_ready pattern on cycles with no request

   function automatic out_t mk(logic req, logic we, logic iod, logic irw,
                               logic pcw, logic pcs, logic [1:0] op,
                               logic [1:0] a, logic [1:0] b, logic rw,
                               logic [1:0] wb, logic ill, logic ret);
      out_t o;
      o.req = req; o.we = we; o.iod = iod; o.irw = irw; o.pcw = pcw;
      o.pcs = pcs; o.op = op; o.a = a; o.b = b; o.rw = rw; o.wb = wb;
      o.ill = ill; o.ret = ret;
      return o;
   endfunction

   task automatic push(input logic rst, input logic rdy, input out_t exp);
      step_t s;
      s.rst = rst; s.rdy = rdy; s.opc = m_opc; s.f3 = m_f3;
      s.zero = m_zero; s.lt = m_lt; s.exp = exp;
      q.push_back(s);
   endtask

   // Cycle with no memory request: mem_ready alternates and must be ignored.
   task automatic push_idle(input out_t exp);
      tog = ~tog;
      push(1'b1, tog, exp);
   endtask

   task automatic plan_reset(input int n);
      for (int i = 0; i < n; i++) push(1'b0, 1'b1, '0);
   endtask

   function automatic logic br_taken(logic [2:0] f3, logic z, logic lt);
      case (f3)
         3'b000:         return z;
         3'b001:         return !z;
         3'b100, 3'b110: return lt;
         3'b101, 3'b111: return !lt;
         default:        return 1'b0;
      endcase
   endfunction

   task automatic plan_instr(input logic [6:0] opc, input logic [2:0] f3,
                             input logic zero, input logic lt, input int fw,
                             input int mw, input int n_trap);
      logic tk;
      m_opc = opc; m_f3 = f3; m_zero = zero; m_lt = lt;
      // fetch: PC+4 on the ALU, request from PC
      for (int i = 0; i < fw; i++)
         push(1'b1, 1'b0, mk(1,0,0,0,0,0, 2'b00,2'b00,2'b01, 0,2'b00, 0,0));
      push(1'b1, 1'b1, mk(1,0,0,1,1,0, 2'b00,2'b00,2'b01, 0,2'b00, 0,0));
      // decode: oldPC + imm
      push_idle(mk(0,0,0,0,0,0, 2'b00,2'b01,2'b10, 0,2'b00, 0,0));
      case (opc)
         OP_R, OP_I: begin
            if (opc == OP_R) push_idle(mk(0,0,0,0,0,0, 2'b10,2'b10,2'b00, 0,2'b00, 0,0));
            else             push_idle(mk(0,0,0,0,0,0, 2'b11,2'b10,2'b10, 0,2'b00, 0,0));
            push_idle(mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,2'b00, 0,1));
         end
         OP_LOAD: begin
            push_idle(mk(0,0,0,0,0,0, 2'b00,2'b10,2'b10, 0,2'b00, 0,0));
            for (int i = 0; i < mw; i++)
               push(1'b1, 1'b0, mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 0,0));
            push(1'b1, 1'b1, mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 0,0));
            push_idle(mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,2'b01, 0,1));
         end
         OP_STORE: begin
            push_idle(mk(0,0,0,0,0,0, 2'b00,2'b10,2'b10, 0,2'b00, 0,0));
            for (int i = 0; i < mw; i++)
               push(1'b1, 1'b0, mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 0,0));
            if (mw >= 0)
               push(1'b1, 1'b1, mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 0,1));
         end
         OP_BRANCH: begin
            if (f3 == 3'b010 || f3 == 3'b011) begin
               push_idle(mk(0,0,0,0,0,0, 2'b01,2'b10,2'b00, 0,2'b00, 0,0));
               for (int i = 0; i < n_trap; i++)
                  push_idle(mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 1,0));
            end else begin
               tk = br_taken(f3, zero, lt);
               push_idle(mk(0,0,0,0,tk,tk, 2'b01,2'b10,2'b00, 0,2'b00, 0,1));
            end
         end
         OP_JAL:
            push_idle(mk(0,0,0,0,1,1, 2'b00,2'b00,2'b00, 1,2'b10, 0,1));
         OP_LUI:
            push_idle(mk(0,0,0,0,0,0, 2'b00,2'b11,2'b10, 1,2'b00, 0,1));
         default:
            for (int i = 0; i < n_trap; i++)
               push_idle(mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 1,0));
      endcase
   endtask

   // Store abandoned by reset: one wait cycle, then reset asserted.
   task automatic plan_store_reset();
      m_opc = OP_STORE; m_f3 = 3'b010; m_zero = 0; m_lt = 0;
      push(1'b1, 1'b1, mk(1,0,0,1,1,0, 2'b00,2'b00,2'b01, 0,2'b00, 0,0));
      push_idle(mk(0,0,0,0,0,0, 2'b00,2'b01,2'b10, 0,2'b00, 0,0));
      push_idle(mk(0,0,0,0,0,0, 2'b00,2'b10,2'b10, 0,2'b00, 0,0));
      push(1'b1, 1'b0, mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 0,0));
      plan_reset(2);   // mem_ready=1 during reset must not complete the store
   endtask

   // ---------------------------------------------------------------------------
   // Driver and compare process.
   // ---------------------------------------------------------------------------
   out_t exp_vec = '0;
   logic exp_valid = 1'b0;
   int   cyc = 0, last_len = 0, retire_total = 0, req_total = 0, dreq_total = 0;

   task automatic run();
      step_t s;
      while (q.size() > 0) begin
         @(negedge clk);
         s = q.pop_front();
         rst_n = s.rst; mem_ready = s.rdy; opcode = s.opc; funct3 = s.f3;
         alu_zero = s.zero; alu_lt = s.lt;
         exp_vec = s.exp; exp_valid = 1'b1;
      end
      #3;   // let the compare process finish this cycle
   endtask

   always @(negedge clk) begin
      #2;
      if (exp_valid) begin
         check("outputs", got, exp_vec);
         if (!rst_n) cyc = 0;
         else        cyc++;
         if (mem_req)           req_total++;
         if (mem_req && i_or_d) dreq_total++;
         if (instr_retired) begin
            retire_total++;
            last_len = cyc;
            cyc = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   int r0, q0;

   initial begin
      // reset state
      plan_reset(2);
      run();
      check("reset_outputs", got, 32'h0);

      // add, zero-wait: 4 cycles, one retire
      r0 = retire_total;
      plan_instr(OP_R, 3'b000, 0, 0, 0, 0, 0);
      run();
      check("add_cycles", last_len, 4);
      check("add_retires", retire_total - r0, 1);

      // addi
      plan_instr(OP_I, 3'b000, 0, 0, 0, 0, 0);
      run();
      check("addi_cycles", last_len, 4);

      // add with 2 fetch wait cycles
      plan_instr(OP_R, 3'b000, 0, 0, 2, 0, 0);
      run();
      check("add_fetchwait_cycles", last_len, 6);

      // lw with 3 wait cycles
      q0 = dreq_total;
      plan_instr(OP_LOAD, 3'b010, 0, 0, 0, 3, 0);
      run();
      check("lw_wait_cycles", last_len, 8);
      check("lw_data_req_cycles", dreq_total - q0, 4);

      // sw zero-wait and with 2 waits
      plan_instr(OP_STORE, 3'b010, 0, 0, 0, 0, 0);
      run();
      check("sw_cycles", last_len, 4);
      plan_instr(OP_STORE, 3'b010, 0, 0, 0, 2, 0);
      run();
      check("sw_wait_cycles", last_len, 6);

      // branches: beq taken / not taken, then the other conditions
      plan_instr(OP_BRANCH, 3'b000, 1, 0, 0, 0, 0);
      run();
      check("beq_taken_cycles", last_len, 3);
      check("beq_taken_pc_write", pc_write, 1);
      plan_instr(OP_BRANCH, 3'b000, 0, 0, 0, 0, 0);
      run();
      check("beq_not_taken_cycles", last_len, 3);
      check("beq_not_taken_pc_write", pc_write, 0);
      plan_instr(OP_BRANCH, 3'b001, 0, 0, 0, 0, 0);
      plan_instr(OP_BRANCH, 3'b100, 0, 1, 0, 0, 0);
      plan_instr(OP_BRANCH, 3'b101, 0, 1, 0, 0, 0);
      plan_instr(OP_BRANCH, 3'b110, 1, 0, 0, 0, 0);
      plan_instr(OP_BRANCH, 3'b111, 1, 0, 0, 0, 0);
      run();

      // jal and lui
      plan_instr(OP_JAL, 3'b000, 0, 0, 0, 0, 0);
      run();
      check("jal_cycles", last_len, 3);
      plan_instr(OP_LUI, 3'b000, 0, 0, 0, 0, 0);
      run();
      check("lui_cycles", last_len, 3);

      // illegal opcode: trap for 20 cycles, only the fetch ever requested
      q0 = req_total; r0 = retire_total;
      plan_instr(7'b0000000, 3'b000, 0, 0, 0, 0, 20);
      run();
      check("trap_flag", illegal_instr, 1);
      check("trap_req_cycles", req_total - q0, 1);
      check("trap_retires", retire_total - r0, 0);
      plan_reset(1);
      plan_instr(OP_R, 3'b000, 0, 0, 0, 0, 0);
      run();
      check("after_trap_add_cycles", last_len, 4);

      // branch with funct3 010 traps without retiring
      r0 = retire_total;
      plan_instr(OP_BRANCH, 3'b010, 1, 1, 0, 0, 5);
      run();
      check("bad_branch_retires", retire_total - r0, 0);
      plan_reset(1);
      run();

      // reset during a store wait: abandoned, FETCH next
      r0 = retire_total;
      plan_store_reset();
      run();
      check("store_reset_retires", retire_total - r0, 0);
      plan_instr(OP_R, 3'b000, 0, 0, 0, 0, 0);
      run();
      check("after_store_reset_add_cycles", last_len, 4);

`ifdef MC_CTRL_PERF_EN
      plan_reset(1);
      for (int i = 0; i < 10; i++) plan_instr(OP_I, 3'b000, 0, 0, 0, 0, 0);
      m_opc = OP_R;
      push(1'b1, 1'b0, mk(1,0,0,0,0,0, 2'b00,2'b00,2'b01, 0,2'b00, 0,0));
      run();
      check("instret_cnt_10", instret_cnt, 10);
      check("cycle_cnt_40", cycle_cnt, 40);
      force dut.r_cycle_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_cycle_cnt;
      push(1'b1, 1'b0, mk(1,0,0,0,0,0, 2'b00,2'b00,2'b01, 0,2'b00, 0,0));
      run();
      check("cycle_cnt_wrap", cycle_cnt, 0);
`endif

      exp_valid = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32I core. It sequences the shared ALU, register file and unified memory port across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps. It drives the 2-bit `alu_op` consumed by the ALU control decoder, plus all mux selects and write enables, and handshakes with memory through a req/ready pair.

## Interface
- No parameters.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `opcode` in 7: instruction register [6:0].
- `funct3` in 3: instruction register [14:12].
- `alu_zero` in 1: ALU result == 0.
- `alu_lt` in 1: ALU less-than flag; the datapath selects signed or unsigned from funct3.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: store.
- `i_or_d` out 1: 0 = address from PC, 1 = address from ALUOut.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: load the PC; also latches oldPC.
- `pc_src` out 1: 0 = ALU result, 1 = ALUOut.
- `alu_op` out 2: 00 add, 01 subtract/compare, 10 R-type decode, 11 I-type decode.
- `alu_src_a` out 2: 00 PC, 01 oldPC, 10 rs1, 11 zero.
- `alu_src_b` out 2: 00 rs2, 01 constant 4, 10 imm.
- `reg_write` out 1: register file write.
- `wb_sel` out 2: 00 ALUOut, 01 memory data, 10 PC.
- `illegal_instr` out 1: sticky trap flag.
- `instr_retired` out 1: one-cycle pulse per completed instruction.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, LOAD_WB, MEM_WR, BRANCH, JAL, LUI_WB, TRAP.
- FETCH: `mem_req`=1, `i_or_d`=0. `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00 (PC+4).
  - While `mem_ready`=0: stay in FETCH, with all enables 0.
  - On `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
- DECODE: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00; ALUOut receives the branch/jump target. Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI_WB
  - any other opcode → TRAP
- EXEC_R: a=10, b=00, op=10, then ALU_WB.
- EXEC_I: a=10, b=10, op=11, then ALU_WB.
- ALU_WB: `reg_write`=1, `wb_sel`=00, `instr_retired`=1, then FETCH.
- MEM_ADDR: a=10, b=10, op=00. Next is MEM_RD for a load, MEM_WR for a store.
- MEM_RD: `mem_req`=1, `i_or_d`=1. Holds until `mem_ready`, then LOAD_WB.
- LOAD_WB: `reg_write`=1, `wb_sel`=01, retire, then FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `i_or_d`=1. Holds until `mem_ready`; retires in the `mem_ready` cycle, then FETCH.
- BRANCH: a=10, b=00, op=01. Taken condition by funct3:
  - beq (000): `alu_zero`
  - bne (001): !`alu_zero`
  - blt (100) / bltu (110): `alu_lt`
  - bge (101) / bgeu (111): !`alu_lt`
  - If taken: `pc_write`=1, `pc_src`=1.
  - Always retires, then FETCH.
  - funct3 010 or 011 → TRAP with no retire.
- JAL: `pc_write`=1, `pc_src`=1, `reg_write`=1, `wb_sel`=10 (PC already holds oldPC+4), retire, then FETCH.
- LUI_WB: a=11, b=10, op=00, `reg_write`=1, `wb_sel`=00 (writes the ALU result directly), retire, then FETCH.
- TRAP: all enables 0, `illegal_instr`=1. Stays in TRAP until reset.
- Output defaults in every state: any output not listed is 0.

## Timing
- While `rst_n`=0 at a clock edge:
  - State is set to FETCH and `illegal_instr` is cleared.
  - All outputs are forced to 0, including `mem_req`.
  - The first request is issued in the first cycle after release.
- Outputs are combinational from state. In FETCH, `ir_write` and `pc_write` are also qualified by `mem_ready`.
- Handshake:
  - `mem_req` stays high and the address and `mem_we` stay stable until `mem_ready` is sampled high.
  - `mem_ready` without `mem_req` is ignored.
  - A request completes in the same cycle `mem_ready` is seen.
- Cycle counts with zero-wait memory: R/I 4, load 5, store 4, branch 3, JAL 3, LUI 3. Each memory wait cycle adds 1.
- Reset mid-instruction (for example during a MEM_WR wait): the access is abandoned and no retire pulse is produced.

## Configuration
- `MC_CTRL_PERF_EN` defined adds outputs `cycle_cnt`[31:0] and `instret_cnt`[31:0].
  - Both reset to 0.
  - `cycle_cnt` increments every cycle except in TRAP.
  - `instret_cnt` increments on `instr_retired`.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters are absent. FSM behaviour is identical either way.

## Test plan
- `add`, opcode 0110011, zero-wait memory:
  - States FETCH→DECODE→EXEC_R→ALU_WB, with `alu_op`=10 in EXEC_R.
  - `reg_write` pulses in cycle 4; `instr_retired`=1 exactly once.
- `lw` with `mem_ready` held low for 3 cycles in MEM_RD: `mem_req` stays high 4 cycles with `i_or_d`=1, then LOAD_WB with `wb_sel`=01. Total 8 cycles.
- `beq`:
  - With `alu_zero`=1: `pc_write`=1, `pc_src`=1 in BRANCH.
  - With `alu_zero`=0: `pc_write`=0.
  - Both retire after 3 cycles.
- Opcode 0000000:
  - TRAP after DECODE; `illegal_instr`=1 and no further `mem_req` for 20 cycles.
  - `rst_n` low for one edge clears the flag and FETCH resumes.
- Reset asserted during a MEM_WR wait: `mem_req` is 0 in the following cycle, no `instr_retired`, and the next state is FETCH.
- With `MC_CTRL_PERF_EN`, 10 back-to-back `addi`: `instret_cnt`=10, `cycle_cnt`=40. Forcing the counter to 0xFFFFFFFF wraps it to 0.
